// File: rtl/des_dec_key_sched.sv
// Iterative DES key schedule, decrypt order: presents K16 first down to K1, one per transfer.
// Optional load-time odd-parity key check is enabled by defining DES_KEY_PARITY_CHK_EN.
module des_dec_key_sched (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] key_in,
    input  logic        key_load,
    output logic        key_busy,
    output logic [47:0] subkey,
    output logic [3:0]  subkey_round,
    output logic        subkey_valid,
    input  logic        subkey_ready,
    output logic        done,
`ifdef DES_KEY_PARITY_CHK_EN
    output logic        parity_err,
`endif
    output logic        state_dbg
);

    typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

    // DES bit numbers (1 = MSB) selected by PC-1 (C half then D half) and by PC-2.
    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    state_t      state;
    logic [27:0] c, d;
    logic [3:0]  cnt;
    logic [55:0] pc1_out;
    logic [55:0] cd;
    logic        rot_one;
    logic [27:0] c_next, d_next;

    always_comb begin
        pc1_out = '0;
        for (int j = 0; j < 56; j++) pc1_out[6'(55 - j)] = key_in[6'(64 - PC1[j])];
    end

    assign cd = {c, d};

    always_comb begin
        subkey = '0;
        for (int k = 0; k < 48; k++) subkey[6'(47 - k)] = cd[6'(56 - PC2[k])];
    end

    // Undo the encrypt left shift of round cnt+1: rounds 1, 2, 9 and 16 shift by one.
    assign rot_one = (cnt == 4'd0) || (cnt == 4'd1) || (cnt == 4'd8) || (cnt == 4'd15);
    assign c_next  = rot_one ? {c[0], c[27:1]} : {c[1:0], c[27:2]};
    assign d_next  = rot_one ? {d[0], d[27:1]} : {d[1:0], d[27:2]};

`ifdef DES_KEY_PARITY_CHK_EN
    logic par_ok;
    always_comb begin
        par_ok = 1'b1;
        for (int i = 0; i < 8; i++) if (!(^key_in[i*8 +: 8])) par_ok = 1'b0;
    end
`endif

    // Handshake: a subkey transfers on a rising edge where subkey_valid && subkey_ready;
    // subkey and subkey_round stay stable while valid is high and ready is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            c     <= '0;
            d     <= '0;
            cnt   <= '0;
            done  <= 1'b0;
`ifdef DES_KEY_PARITY_CHK_EN
            parity_err <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (key_load) begin
`ifdef DES_KEY_PARITY_CHK_EN
                        if (par_ok) begin
                            parity_err <= 1'b0;
                            c     <= pc1_out[55:28];
                            d     <= pc1_out[27:0];
                            cnt   <= 4'd15;
                            state <= EMIT;
                        end else begin
                            parity_err <= 1'b1;
                        end
`else
                        c     <= pc1_out[55:28];
                        d     <= pc1_out[27:0];
                        cnt   <= 4'd15;
                        state <= EMIT;
`endif
                    end
                end
                EMIT: begin
                    if (subkey_ready) begin
                        if (cnt == 4'd0) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end else begin
                            c   <= c_next;
                            d   <= d_next;
                            cnt <= cnt - 4'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign key_busy     = (state == EMIT);
    assign subkey_valid = (state == EMIT);
    assign subkey_round = cnt;
    assign state_dbg    = state;

endmodule

// File: tb/tb_des_dec_key_sched.sv
// Directed bench for des_dec_key_sched: expected subkeys queued at load, checked as they appear.
module tb_des_dec_key_sched;

    localparam logic [63:0] KEY = 64'h133457799BBCDFF1;
`ifdef DES_KEY_PARITY_CHK_EN
    localparam logic [63:0] KEY_ZERO = 64'h0101010101010101;
`else
    localparam logic [63:0] KEY_ZERO = 64'h0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] key_in = '0;
    logic        key_load = 1'b0;
    logic        key_busy;
    logic [47:0] subkey;
    logic [3:0]  subkey_round;
    logic        subkey_valid;
    logic        subkey_ready = 1'b1;
    logic        done;
    logic        state_dbg;
`ifdef DES_KEY_PARITY_CHK_EN
    logic        parity_err;
`endif

    int tests_run = 0;
    int fail_cnt  = 0;
    logic [51:0] exp_q[$];
    bit done_pending = 0;

    // Reference subkeys for KEY, index 0 = K1.
    logic [47:0] ks_ref [16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };

    des_dec_key_sched dut (
        .clk          (clk),
        .rst          (rst),
        .key_in       (key_in),
        .key_load     (key_load),
        .key_busy     (key_busy),
        .subkey       (subkey),
        .subkey_round (subkey_round),
        .subkey_valid (subkey_valid),
        .subkey_ready (subkey_ready),
        .done         (done),
`ifdef DES_KEY_PARITY_CHK_EN
        .parity_err   (parity_err),
`endif
        .state_dbg    (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        assert (got === exp) else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push_seq(input bit zero);
        for (int r = 15; r >= 0; r--) exp_q.push_back({4'(r), zero ? 48'h0 : ks_ref[r]});
    endtask

    task automatic do_load(input logic [63:0] k);
        @(posedge clk); #1;
        key_in   = k;
        key_load = 1'b1;
        @(posedge clk); #1;
        key_load = 1'b0;
        push_seq(k == KEY_ZERO);
    endtask

    task automatic wait_empty(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        check(tag, 64'(exp_q.size()), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    // Scoreboard: compare the presented subkey each cycle, pop on transfer.
    always @(negedge clk) begin
        logic [51:0] e;
        if (rst) begin
            done_pending = 0;
        end else begin
            check("done", done, done_pending);
            done_pending = 0;
            check("valid", subkey_valid, exp_q.size() != 0);
            check("busy", key_busy, exp_q.size() != 0);
            if (subkey_valid && exp_q.size() != 0) begin
                check("round", subkey_round, exp_q[0][51:48]);
                check("subkey", subkey, exp_q[0][47:0]);
                if (subkey_ready) begin
                    e = exp_q.pop_front();
                    if (e[51:48] == 4'd0) done_pending = 1;
                end
            end
        end
    end

    initial begin
        int n;
        bit seen;
        bit [3:0] pat;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", key_busy, 0);
        check("rst_valid", subkey_valid, 0);
        check("rst_done", done, 0);
        check("rst_round", subkey_round, 0);
        check("rst_subkey", subkey, 0);
        check("rst_state", state_dbg, 0);
`ifdef DES_KEY_PARITY_CHK_EN
        check("rst_perr", parity_err, 0);
`endif
        rst = 1'b0;

`ifdef DES_KEY_PARITY_CHK_EN
        // Bad parity key is rejected
        @(posedge clk); #1;
        key_in   = 64'h133457799BBCDFF0;
        key_load = 1'b1;
        @(posedge clk); #1;
        key_load = 1'b0;
        check("perr_set", parity_err, 1);
        check("perr_busy", key_busy, 0);
        check("perr_valid", subkey_valid, 0);
        do_load(KEY);
        check("perr_clr", parity_err, 0);
        wait_empty("perr_seq_drain");
`endif

        // Full throughput with ready high
        do_load(KEY);
        wait_empty("full_drain");

        // Ready toggling 1-0-0-1
        pat = 4'b1001;
        do_load(KEY);
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            subkey_ready = pat[3 - (n % 4)];
            n++;
        end
        subkey_ready = 1'b1;
        wait_empty("stall_drain");

        // Loads during EMIT ignored; load in the done cycle accepted
        @(posedge clk); #1;
        key_in   = KEY;
        key_load = 1'b1;
        @(posedge clk); #1;
        key_in = KEY_ZERO;
        push_seq(0);
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
        end
        check("done_seen", seen, 1);
        @(posedge clk); #1;
        key_load = 1'b0;
        push_seq(1);
        wait_empty("zero_drain");

        // Reset after 5 transfers
        do_load(KEY);
        n = 0;
        while (exp_q.size() > 11 && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        check("five_xfers", 64'(exp_q.size()), 64'd11);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("arst_busy", key_busy, 0);
        check("arst_valid", subkey_valid, 0);
        check("arst_done", done, 0);
        exp_q.delete();
        @(posedge clk); #2;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        do_load(KEY);
        wait_empty("reload_drain");

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end

endmodule
